// File: rtl/busytone_cmd_resp_if.sv
// Command-in / ack-out AXI-Stream pair for the busy-tone responder.
// The master side feeds CHDR command packets and drains ACK packets,
// the slave side is the responder block itself.
interface busytone_cmd_resp_if;
  logic [63:0] cmd_in_TDATA;
  logic        cmd_in_TVALID;
  logic        cmd_in_TREADY;
  logic        cmd_in_TLAST;
  logic [63:0] ack_out_TDATA;
  logic        ack_out_TVALID;
  logic        ack_out_TREADY;
  logic        ack_out_TLAST;

  modport master (
    output cmd_in_TDATA, cmd_in_TVALID, cmd_in_TLAST,
    input  cmd_in_TREADY,
    input  ack_out_TDATA, ack_out_TVALID, ack_out_TLAST,
    output ack_out_TREADY
  );

  modport slave (
    input  cmd_in_TDATA, cmd_in_TVALID, cmd_in_TLAST,
    output cmd_in_TREADY,
    output ack_out_TDATA, ack_out_TVALID, ack_out_TLAST,
    input  ack_out_TREADY
  );
endinterface

// File: rtl/busytone_cmd_resp.sv
// Busy-tone command responder: parses CHDR settings writes, runs the
// cycle-accurate tone window counter and returns one ACK per accepted command.
module busytone_cmd_resp #(
  parameter logic [7:0] TRIG_ADDR = 8'd200,
  parameter logic [7:0] HOLD_ADDR = 8'd201,
  parameter int         CNT_W     = 32
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  busytone_cmd_resp_if.slave bus,
  input  logic [15:0]        src_sid_V,
  output logic               tone_active,
  output logic [CNT_W-1:0]   tone_remaining_V,
  output logic [15:0]        drop_count_V
);

  typedef enum logic [2:0] {
    ST_HDR,
    ST_TIME,
    ST_PAY,
    ST_DRAIN,
    ST_ACK_H,
    ST_ACK_P
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             in_ready;
  logic             in_xfer;
  logic             ack_xfer;
  logic             drain_to_ack;
  logic             drain_to_ack_next;
  logic             drop_evt;
  logic             exec_evt;

  logic [63:0]      word;
  logic [7:0]       cmd_addr;
  logic [31:0]      cmd_data;
  logic [8:0]       unused_word_bits;

  logic [11:0]      seq_q;
  logic [15:0]      src_q;
  logic [7:0]       addr_q;
  logic [31:0]      readback_q;
  logic [31:0]      readback_next;
  logic [31:0]      hold_q;

  logic [CNT_W-1:0] tone_q;
  logic             tone_act_q;
  logic [CNT_W-1:0] tone_dec;
  logic [CNT_W-1:0] tone_floor;
  logic [CNT_W-1:0] tone_load;
  logic [CNT_W-1:0] tone_next;
  logic [CNT_W-1:0] data_ext;
  logic [CNT_W-1:0] hold_ext;

  logic [15:0]      drop_q;
  logic             ack_valid;
  logic             ack_last;
  logic [63:0]      ack_data;

  assign word             = bus.cmd_in_TDATA;
  assign cmd_addr         = word[39:32];
  assign cmd_data         = word[31:0];
  assign unused_word_bits = {word[60], word[47:40]};
  assign data_ext         = CNT_W'(cmd_data);
  assign hold_ext         = CNT_W'(hold_q);

  assign in_xfer  = bus.cmd_in_TVALID && in_ready;
  assign ack_xfer = ack_valid && bus.ack_out_TREADY;

  assign bus.cmd_in_TREADY  = in_ready;
  assign bus.ack_out_TVALID = ack_valid;
  assign bus.ack_out_TLAST  = ack_last;
  assign bus.ack_out_TDATA  = ack_data;
  assign tone_active        = tone_act_q;
  assign tone_remaining_V   = tone_q;
  assign drop_count_V       = drop_q;

  // Packet parser: walks header/time/payload, routes malformed or over-length packets through DRAIN
  always_comb begin
    state_next        = state;
    drain_to_ack_next = drain_to_ack;
    drop_evt          = 1'b0;
    exec_evt          = 1'b0;
    case (state)
      ST_HDR: begin
        if (in_xfer) begin
          if (word[63:62] != 2'b10 || bus.cmd_in_TLAST) begin
            drop_evt          = 1'b1;
            drain_to_ack_next = 1'b0;
            state_next        = bus.cmd_in_TLAST ? ST_HDR : ST_DRAIN;
          end else begin
            state_next = word[61] ? ST_TIME : ST_PAY;
          end
        end
      end
      ST_TIME: begin
        if (in_xfer) begin
          if (bus.cmd_in_TLAST) begin
            drop_evt   = 1'b1;
            state_next = ST_HDR;
          end else begin
            state_next = ST_PAY;
          end
        end
      end
      ST_PAY: begin
        if (in_xfer) begin
          exec_evt = 1'b1;
          if (bus.cmd_in_TLAST) begin
            state_next = ST_ACK_H;
          end else begin
            drain_to_ack_next = 1'b1;
            state_next        = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (in_xfer && bus.cmd_in_TLAST) begin
          state_next = drain_to_ack ? ST_ACK_H : ST_HDR;
        end
      end
      ST_ACK_H: begin
        if (ack_xfer) state_next = ST_ACK_P;
      end
      ST_ACK_P: begin
        if (ack_xfer) state_next = ST_HDR;
      end
      default: state_next = ST_HDR;
    endcase
  end

  // Parser state and registered input-ready (low out of reset and while an ACK is pending)
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state        <= ST_HDR;
      in_ready     <= 1'b0;
      drain_to_ack <= 1'b0;
    end else begin
      state        <= state_next;
      in_ready     <= (state_next inside {ST_HDR, ST_TIME, ST_PAY, ST_DRAIN});
      drain_to_ack <= drain_to_ack_next;
    end
  end

  // Next tone count: plain decrement, overridden by a trigger that may only extend or close the window
  always_comb begin
    tone_dec   = (tone_q == '0) ? '0 : tone_q - CNT_W'(1);
    tone_floor = (data_ext > hold_ext) ? data_ext : hold_ext;
    tone_load  = (tone_floor > tone_dec) ? tone_floor : tone_dec;
    tone_next  = tone_dec;
    if (exec_evt && cmd_addr == TRIG_ADDR) begin
      tone_next = (cmd_data != 32'd0) ? tone_load : '0;
    end
  end

  // Value echoed in the ACK payload: post-command window length, new hold, or a marker for unknown addresses
  always_comb begin
    if (cmd_addr == TRIG_ADDR) begin
      readback_next = 32'(tone_next);
    end else if (cmd_addr == HOLD_ADDR) begin
      readback_next = cmd_data;
    end else begin
      readback_next = 32'h0BADC0DE;
    end
  end

  // Tone window counter and its registered active flag
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      tone_q     <= '0;
      tone_act_q <= 1'b0;
    end else begin
      tone_q     <= tone_next;
      tone_act_q <= (tone_next != '0);
    end
  end

  // Minimum-hold register, loaded by a write to the hold address
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      hold_q <= 32'd0;
    end else if (exec_evt && cmd_addr == HOLD_ADDR) begin
      hold_q <= cmd_data;
    end
  end

  // Capture header fields and the executed command for the ACK
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      seq_q      <= 12'd0;
      src_q      <= 16'd0;
      addr_q     <= 8'd0;
      readback_q <= 32'd0;
    end else begin
      if (state == ST_HDR && in_xfer) begin
        seq_q <= word[59:48];
        src_q <= word[31:16];
      end
      if (exec_evt) begin
        addr_q     <= cmd_addr;
        readback_q <= readback_next;
      end
    end
  end

  // Saturating count of discarded packets
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      drop_q <= 16'd0;
    end else if (drop_evt && drop_q != 16'hFFFF) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  // Registered ACK words, loaded on entry to each ACK state and held while the sink stalls
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ack_valid <= 1'b0;
      ack_last  <= 1'b0;
      ack_data  <= 64'd0;
    end else begin
      ack_valid <= (state_next == ST_ACK_H) || (state_next == ST_ACK_P);
      ack_last  <= (state_next == ST_ACK_P);
      if (state != ST_ACK_H && state_next == ST_ACK_H) begin
        ack_data <= {2'b11, 1'b0, 1'b0, seq_q, 16'd16, src_sid_V, src_q};
      end else if (state == ST_ACK_H && state_next == ST_ACK_P) begin
        ack_data <= {24'd0, addr_q, readback_q};
      end
    end
  end

endmodule

// File: tb/tb_busytone_cmd_resp.sv
// Randomised bench for busytone_cmd_resp: the tone window is modelled as an
// absolute end cycle, ACKs and drop counts are predicted per packet.
module tb_busytone_cmd_resp;

  localparam logic [7:0] TRIG = 8'd200;
  localparam logic [7:0] HOLD = 8'd201;

  logic        ap_clk;
  logic        ap_rst_n;
  logic [15:0] src_sid_V;
  logic        tone_active;
  logic [31:0] tone_remaining_V;
  logic [15:0] drop_count_V;

  busytone_cmd_resp_if bus ();

  busytone_cmd_resp #(
    .TRIG_ADDR(8'd200),
    .HOLD_ADDR(8'd201),
    .CNT_W    (32)
  ) dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .bus             (bus),
    .src_sid_V       (src_sid_V),
    .tone_active     (tone_active),
    .tone_remaining_V(tone_remaining_V),
    .drop_count_V    (drop_count_V)
  );

  int          vectors = 0;
  int          miscompares = 0;
  longint      cyc = 0;
  longint      tone_end = 0;
  longint      hold_m = 0;
  int          drops_m = 0;
  bit          mon_en = 0;
  logic [63:0] pkt_w [0:7];
  int          pkt_n;
  bit          ack_pending;
  logic [63:0] exp_hdr;
  logic [63:0] exp_pay;

  // Free-running clock and edge counter used as the model's time base
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic failBudget(input string tag);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: wait bound expired (cycle %0d)", tag, cyc);
  endtask

  // Every cycle: tone outputs follow the end-cycle model, drop count follows the packet model
  always @(negedge ap_clk) begin
    if (mon_en) begin
      longint r;
      r = tone_end - cyc;
      if (r < 0) r = 0;
      checkOutput("tone_rem", 64'(tone_remaining_V), 64'(r));
      checkOutput("tone_act", 64'(tone_active), 64'(r != 0));
      checkOutput("drop_cnt", 64'(drop_count_V), 64'(drops_m));
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  task automatic buildPkt(input logic [1:0] typ, input bit ht, input logic [11:0] seq,
                          input logic [15:0] src, input logic [7:0] addr,
                          input logic [31:0] data, input int extra);
    pkt_w[0] = {typ, ht, 1'($urandom), seq, 16'($urandom), src, 16'($urandom)};
    pkt_n = 1;
    if (ht) begin
      pkt_w[1] = {$urandom, $urandom};
      pkt_n = 2;
    end
    pkt_w[pkt_n] = {24'($urandom), addr, data};
    pkt_n++;
    for (int k = 0; k < extra; k++) begin
      pkt_w[pkt_n] = {$urandom, $urandom};
      pkt_n++;
    end
  endtask

  // Send pkt_w with random valid bubbles; update the model at each deciding handshake
  task automatic applyStimulus();
    logic [63:0] hdr;
    int          drop_idx;
    int          pay_idx;
    int          budget;
    longint      e;
    longint      m;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] rb;
    hdr      = pkt_w[0];
    drop_idx = -1;
    pay_idx  = -1;
    if (hdr[63:62] != 2'b10 || pkt_n == 1) drop_idx = 0;
    else if (hdr[61] && pkt_n == 2)        drop_idx = 1;
    else                                   pay_idx = hdr[61] ? 2 : 1;
    ack_pending = (drop_idx < 0);
    exp_hdr = {2'b11, 1'b0, 1'b0, hdr[59:48], 16'd16, src_sid_V, hdr[31:16]};
    for (int i = 0; i < pkt_n; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        bus.cmd_in_TVALID = 1'b0;
        @(posedge ap_clk);
        #1;
      end
      bus.cmd_in_TDATA  = pkt_w[i];
      bus.cmd_in_TLAST  = (i == pkt_n - 1);
      bus.cmd_in_TVALID = 1'b1;
      budget = 0;
      @(negedge ap_clk);
      while (!bus.cmd_in_TREADY && budget < 500) begin
        @(negedge ap_clk);
        budget++;
      end
      if (!bus.cmd_in_TREADY) begin
        failBudget("cmd_ready_timeout");
        bus.cmd_in_TVALID = 1'b0;
        ack_pending = 0;
        return;
      end
      @(posedge ap_clk);
      #1;
      bus.cmd_in_TVALID = 1'b0;
      bus.cmd_in_TLAST  = 1'b0;
      if (i == drop_idx) drops_m = (drops_m == 65535) ? 65535 : drops_m + 1;
      if (i == pay_idx) begin
        e = cyc;
        a = pkt_w[i][39:32];
        d = pkt_w[i][31:0];
        if (a == TRIG) begin
          if (d != 32'd0) begin
            m = (longint'(d) > hold_m) ? longint'(d) : hold_m;
            if (e + m > tone_end) tone_end = e + m;
            rb = 32'(tone_end - e);
          end else begin
            tone_end = e;
            rb = 32'd0;
          end
        end else if (a == HOLD) begin
          hold_m = longint'(d);
          rb = d;
        end else begin
          rb = 32'h0BADC0DE;
        end
        exp_pay = {24'd0, a, rb};
      end
    end
  endtask

  // Drain the two ACK words; 'stall' cycles of forced back-pressure come first
  task automatic collectAck(input int stall);
    int budget;
    bit done;
    for (int w = 0; w < 2; w++) begin
      done   = 0;
      budget = 0;
      while (!done) begin
        @(negedge ap_clk);
        budget++;
        if (budget > 300) begin
          failBudget("ack_timeout");
          bus.ack_out_TREADY = 1'b0;
          return;
        end
        if (bus.ack_out_TVALID) begin
          checkOutput(w == 0 ? "ack_hdr" : "ack_pay", bus.ack_out_TDATA, w == 0 ? exp_hdr : exp_pay);
          checkOutput("ack_last", 64'(bus.ack_out_TLAST), 64'(w == 1));
          checkOutput("cmd_stall", 64'(bus.cmd_in_TREADY), 64'd0);
          if (stall > 0) begin
            stall--;
            bus.ack_out_TREADY = 1'b0;
          end else begin
            bus.ack_out_TREADY = ($urandom_range(0, 2) != 0);
          end
          if (bus.ack_out_TREADY) begin
            @(posedge ap_clk);
            #1;
            bus.ack_out_TREADY = 1'b0;
            done = 1;
          end
        end
      end
    end
  endtask

  task automatic runPacket(input int stall);
    applyStimulus();
    if (ack_pending) collectAck(stall);
  endtask

  task automatic checkNow(input string tag, input logic [63:0] got, input logic [63:0] exp);
    @(negedge ap_clk);
    checkOutput(tag, got, exp);
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    int budget;
    int kind;
    logic [7:0] oa;
    bus.cmd_in_TDATA   = 64'd0;
    bus.cmd_in_TVALID  = 1'b0;
    bus.cmd_in_TLAST   = 1'b0;
    bus.ack_out_TREADY = 1'b0;
    src_sid_V          = 16'hA5C3;
    ap_rst_n           = 1'b1;
    #2 ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    checkOutput("rst_cmd_ready", 64'(bus.cmd_in_TREADY), 64'd0);
    checkOutput("rst_ack_valid", 64'(bus.ack_out_TVALID), 64'd0);
    checkOutput("rst_ack_last", 64'(bus.ack_out_TLAST), 64'd0);
    checkOutput("rst_tone_act", 64'(tone_active), 64'd0);
    checkOutput("rst_tone_rem", 64'(tone_remaining_V), 64'd0);
    checkOutput("rst_drops", 64'(drop_count_V), 64'd0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    mon_en = 1;
    $display("[TB] reset released, starting directed commands");

    // Plain trigger of 100 cycles, then let the window expire
    buildPkt(2'b10, 0, 12'd5, 16'h0210, TRIG, 32'd100, 0);
    runPacket(0);
    checkNow("t100_hdr_seen", exp_hdr, {2'b11, 2'b00, 12'd5, 16'd16, 16'hA5C3, 16'h0210});
    waitCycles(110);
    checkNow("t100_closed", 64'(tone_active), 64'd0);

    // Hold minimum stretches a short trigger
    buildPkt(2'b10, 0, 12'd6, 16'h0211, HOLD, 32'd500, 0);
    runPacket(0);
    checkNow("hold_ack_pay", exp_pay[31:0], 64'd500);
    buildPkt(2'b10, 0, 12'd7, 16'h0211, TRIG, 32'd50, 0);
    runPacket(0);
    waitCycles(510);

    // Long trigger, short retrigger mid-window, then explicit stop
    buildPkt(2'b10, 0, 12'd8, 16'h0212, TRIG, 32'd1000, 0);
    runPacket(0);
    waitCycles(195);
    buildPkt(2'b10, 0, 12'd9, 16'h0212, TRIG, 32'd10, 0);
    runPacket(0);
    waitCycles(20);
    buildPkt(2'b10, 0, 12'd10, 16'h0212, TRIG, 32'd0, 0);
    runPacket(0);
    checkNow("stop_closed", 64'(tone_active), 64'd0);
    buildPkt(2'b10, 0, 12'd11, 16'h0212, HOLD, 32'd0, 0);
    runPacket(0);

    // Malformed traffic and a timed command
    buildPkt(2'b00, 0, 12'd12, 16'h0300, TRIG, 32'd77, 1);
    runPacket(0);
    checkNow("drop_type", 64'(drop_count_V), 64'd1);
    buildPkt(2'b10, 0, 12'd13, 16'h0300, TRIG, 32'd77, 0);
    pkt_n = 1;
    runPacket(0);
    checkNow("drop_hdr_last", 64'(drop_count_V), 64'd2);
    buildPkt(2'b10, 1, 12'd14, 16'h0301, TRIG, 32'd20, 0);
    runPacket(0);
    waitCycles(25);

    // Back-pressured ACK followed by a second command
    buildPkt(2'b10, 0, 12'd15, 16'h0400, TRIG, 32'd30, 0);
    runPacket(30);
    buildPkt(2'b10, 0, 12'd16, 16'h0400, 8'd17, 32'h1234, 0);
    runPacket(0);

    // Asynchronous reset while the window is open
    buildPkt(2'b10, 0, 12'd17, 16'h0500, TRIG, 32'd100, 0);
    runPacket(0);
    budget = 0;
    @(negedge ap_clk);
    while ((tone_end - cyc) != 40 && budget < 200) begin
      @(negedge ap_clk);
      budget++;
    end
    if ((tone_end - cyc) != 40) failBudget("rst_window_wait");
    mon_en = 0;
    #1 ap_rst_n = 1'b0;
    #1;
    checkOutput("arst_tone_act", 64'(tone_active), 64'd0);
    checkOutput("arst_tone_rem", 64'(tone_remaining_V), 64'd0);
    checkOutput("arst_drops", 64'(drop_count_V), 64'd0);
    checkOutput("arst_cmd_ready", 64'(bus.cmd_in_TREADY), 64'd0);
    tone_end = 0;
    hold_m   = 0;
    drops_m  = 0;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    mon_en = 1;
    $display("[TB] starting random commands");

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 7);
      case (kind)
        0: buildPkt(2'b10, 0, 12'($urandom), 16'($urandom), TRIG,
                    ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 400)), 0);
        1: buildPkt(2'b10, 1'($urandom), 12'($urandom), 16'($urandom), HOLD,
                    32'($urandom_range(0, 250)), 0);
        2: begin
          oa = 8'($urandom);
          while (oa == TRIG || oa == HOLD) oa = 8'($urandom);
          buildPkt(2'b10, 0, 12'($urandom), 16'($urandom), oa, $urandom, 0);
        end
        3: buildPkt(2'($urandom_range(0, 1)) | {1'b0, 1'($urandom)} | 2'b00 ^ 2'b00,
                    1'($urandom), 12'($urandom), 16'($urandom), TRIG, 32'd300, $urandom_range(0, 2));
        4: begin
          buildPkt(2'b10, 0, 12'($urandom), 16'($urandom), TRIG, 32'd300, 0);
          pkt_n = 1;
        end
        5: buildPkt(2'b10, 1, 12'($urandom), 16'($urandom), TRIG, 32'($urandom_range(1, 300)), 0);
        6: buildPkt(2'b10, 1'($urandom), 12'($urandom), 16'($urandom), TRIG,
                    32'($urandom_range(1, 300)), $urandom_range(1, 3));
        default: begin
          buildPkt(2'b10, 1, 12'($urandom), 16'($urandom), TRIG, 32'd300, 0);
          pkt_n = 2;
        end
      endcase
      if (kind == 3 && pkt_w[0][63:62] == 2'b10) pkt_w[0][63:62] = 2'b11;
      runPacket($urandom_range(0, 5));
      waitCycles($urandom_range(0, 20));
    end

    waitCycles(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
